// File: rtl/prpg_pkg.sv
// -----------------------------------------------------------------------------
// prpg_pkg
// Shared definitions for the PRPG instruction sequencer: instruction field
// widths, the opcode encoding and the sequencer FSM states.
// Optional feature macro used by the sequencer: PRPG_HD_STORE_EN.
// -----------------------------------------------------------------------------
package prpg_pkg;

  localparam int unsigned INSTR_W = 14;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ARG_W   = 8;
  localparam int unsigned TAP_W   = 7;
  localparam int unsigned P_W     = 8;

  typedef enum logic [OP_W-1:0] {
    OP_HALT      = 6'h00,
    OP_CONFIG    = 6'h01,
    OP_INIT      = 6'h02,
    OP_RUN       = 6'h03,
    OP_INIT_ADDR = 6'h04,
    OP_ST_L      = 6'h05,
    OP_ADD_ADDR  = 6'h06,
    OP_LD_L      = 6'h07,
    OP_ST_HD     = 6'h08
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RUN,
    ST_HALTED,
    ST_ERR
  } state_e;

endpackage

// File: rtl/prpg_run_cnt.sv
// -----------------------------------------------------------------------------
// prpg_run_cnt
// Loadable down-counter that turns a run instruction into a burst of
// single-cycle LFSR step pulses.
// Ports:
//   clk        in   clock, all state on posedge
//   rst        in   synchronous active-high reset
//   i_load     in   load i_load_val into the counter
//   i_load_val in   CNT_W burst length
//   i_en       in   counting enabled (sequencer is in RUN)
//   o_step     out  one LFSR shift this cycle
//   o_last     out  counter holds 1: this is the final step of the burst
// -----------------------------------------------------------------------------
module prpg_run_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_step,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_step = i_en && (r_cnt != '0);
  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/prpg_seq_ctrl.sv
// -----------------------------------------------------------------------------
// prpg_seq_ctrl
// Instruction sequencer for the 8-bit PRPG datapath. Walks pc through an
// external program ROM (combinational read), decodes 14-bit instructions
// {op[13:8], arg[7:0]} and drives LFSR config/seed/step strobes plus
// pattern-memory address and store/load strobes.
// Optional feature macro: PRPG_HD_STORE_EN (enables op 001000, st_M_HD;
// without it that opcode is illegal and st_hd_we is tied low).
// Ports:
//   clk       in   clock, all state on posedge
//   rst       in   synchronous active-high reset
//   start     in   begin program at pc=0 (IDLE/HALTED only)
//   pc        out  PC_W program address
//   instr     in   14-bit instruction at pc
//   cfg_we    out  load LFSR tap register from cfg_tap
//   cfg_tap   out  instr[6:0]
//   seed_we   out  load P from seed
//   seed      out  instr[7:0]
//   step      out  advance LFSR one shift
//   mem_addr  out  ADDR_W pattern-memory address
//   st_p_we   out  M[mem_addr] <= P
//   st_hd_we  out  M[mem_addr] <= HD
//   ld_p_we   out  P <= M[mem_addr]
//   busy      out  EXEC or RUN
//   halted    out  HALTED
//   error     out  ERR (sticky until rst)
// -----------------------------------------------------------------------------
module prpg_seq_ctrl
  import prpg_pkg::*;
#(
  parameter int unsigned PC_W   = 6,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  output logic               cfg_we,
  output logic [TAP_W-1:0]   cfg_tap,
  output logic               seed_we,
  output logic [P_W-1:0]     seed,
  output logic               step,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               st_p_we,
  output logic               st_hd_we,
  output logic               ld_p_we,
  output logic               busy,
  output logic               halted,
  output logic               error
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;

  op_e               w_op;
  logic [ARG_W-1:0]  w_arg;
  logic              w_adv;
  logic              w_cnt_load;
  logic              w_step;
  logic              w_last;
  logic              w_cfg_we;
  logic              w_seed_we;
  logic              w_st_p_we;
  logic              w_ld_p_we;
`ifdef PRPG_HD_STORE_EN
  logic              w_st_hd_we;
`endif

  assign w_op  = op_e'(instr[INSTR_W-1:ARG_W]);
  assign w_arg = instr[ARG_W-1:0];

  prpg_run_cnt #(
    .CNT_W (CNT_W)
  ) u_run_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (CNT_W'(w_arg)),
    .i_en       (r_state == ST_RUN),
    .o_step     (w_step),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_adv       = 1'b0;
    w_cnt_load  = 1'b0;
    w_cfg_we    = 1'b0;
    w_seed_we   = 1'b0;
    w_st_p_we   = 1'b0;
    w_ld_p_we   = 1'b0;
`ifdef PRPG_HD_STORE_EN
    w_st_hd_we  = 1'b0;
`endif

    unique case (r_state)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          w_state_nxt = ST_EXEC;
          w_pc_nxt    = '0;
        end
      end

      ST_EXEC: begin
        case (w_op)
          OP_CONFIG: begin
            w_cfg_we = 1'b1;
            w_adv    = 1'b1;
          end
          OP_INIT: begin
            w_seed_we = 1'b1;
            w_adv     = 1'b1;
          end
          OP_RUN: begin
            if (w_arg == '0) begin
              w_adv = 1'b1;
            end else begin
              w_cnt_load  = 1'b1;
              w_state_nxt = ST_RUN;
            end
          end
          OP_INIT_ADDR: begin
            w_addr_nxt = ADDR_W'(w_arg);
            w_adv      = 1'b1;
          end
          OP_ST_L: begin
            w_st_p_we = 1'b1;
            w_adv     = 1'b1;
          end
          OP_ADD_ADDR: begin
            w_addr_nxt = r_addr + ADDR_W'(w_arg);
            w_adv      = 1'b1;
          end
          OP_LD_L: begin
            w_ld_p_we = 1'b1;
            w_adv     = 1'b1;
          end
`ifdef PRPG_HD_STORE_EN
          OP_ST_HD: begin
            w_st_hd_we = 1'b1;
            w_adv      = 1'b1;
          end
`endif
          OP_HALT: begin
            w_state_nxt = ST_HALTED;
          end
          default: begin
            w_state_nxt = ST_ERR;
          end
        endcase
      end

      ST_RUN: begin
        if (w_last) begin
          w_adv = 1'b1;
        end
      end

      ST_ERR: begin
        w_state_nxt = ST_ERR;
      end

      default: begin
        w_state_nxt = ST_ERR;
      end
    endcase

    // Shared pc increment for every advancing instruction and the end of a
    // run burst; stepping past the last ROM address is an error, not a wrap.
    if (w_adv) begin
      if (&r_pc) begin
        w_state_nxt = ST_ERR;
      end else begin
        w_pc_nxt    = r_pc + PC_W'(1);
        w_state_nxt = ST_EXEC;
      end
    end
  end

  assign pc       = r_pc;
  assign mem_addr = r_addr;
  assign cfg_tap  = instr[TAP_W-1:0];
  assign seed     = instr[P_W-1:0];
  assign cfg_we   = w_cfg_we;
  assign seed_we  = w_seed_we;
  assign step     = w_step;
  assign st_p_we  = w_st_p_we;
  assign ld_p_we  = w_ld_p_we;
`ifdef PRPG_HD_STORE_EN
  assign st_hd_we = w_st_hd_we;
`else
  assign st_hd_we = 1'b0;
`endif
  assign busy     = (r_state == ST_EXEC) || (r_state == ST_RUN);
  assign halted   = (r_state == ST_HALTED);
  assign error    = (r_state == ST_ERR);

endmodule
